permutation_sequencer: RTL and testbench

PERMUTATION_SEQUENCER -- requirements
Module: permutation_sequencer

---
 rtl/permutation_sequencer.sv | 102 ++++++++++
 tb/tb_permutation_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/permutation_sequencer.sv
// Round sequencer for an ASCON-style permutation: steps rnd through 12 or 8 rounds.
// Optional macro PERM_SEQ_ABORT_EN adds an abort input that cancels a running permutation.
module permutation_sequencer #(
    parameter int unsigned ROUND_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
`ifdef PERM_SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic       ready,
    output logic       round_en,
    output logic [3:0] rnd,
    output logic [7:0] round_const,
    output logic       last_round,
    output logic       done
);

    localparam logic       P12_MODE  = 1'b0;
    localparam logic [3:0] P12_INIT  = 4'd4;
    localparam logic [3:0] P8_INIT   = 4'd8;
    localparam logic [3:0] LAST_RND  = 4'd15;
    localparam logic [1:0] SLOT_LAST = 2'(ROUND_LATENCY - 1);

    if (ROUND_LATENCY < 1 || ROUND_LATENCY > 4) begin : g_bad_latency
        $error("ROUND_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic [1:0] slot_q, slot_d;
    logic [3:0] k;
    logic       in_run;

    // The mode choice is fully captured by the starting round index.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        slot_d  = slot_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    rnd_d   = (mode == P12_MODE) ? P12_INIT : P8_INIT;
                    slot_d  = 2'd0;
                end
            end
            StRun: begin
`ifdef PERM_SEQ_ABORT_EN
                if (abort) begin
                    state_d = StIdle;
                    slot_d  = 2'd0;
                end else
`endif
                if (slot_q == SLOT_LAST) begin
                    slot_d = 2'd0;
                    if (rnd_q == LAST_RND) begin
                        state_d = StDone;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rnd_q   <= 4'h0;
            slot_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        in_run      = (state_q == StRun);
        k           = rnd_q - P12_INIT;
        ready       = (state_q == StIdle);
        done        = (state_q == StDone);
        rnd         = rnd_q;
        round_en    = in_run && (slot_q == 2'd0);
        last_round  = in_run && (rnd_q == LAST_RND);
        round_const = in_run ? {4'd15 - k, k} : 8'h00;
    end

endmodule

// File: tb/tb_permutation_sequencer.sv
// Directed self-checking bench for permutation_sequencer at ROUND_LATENCY 1 and 3.
module tb_permutation_sequencer;

    localparam logic P12_MODE = 1'b0;
    localparam logic P8_MODE  = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start1, mode1, start3, mode3;
    logic       ready1, round_en1, last1, done1;
    logic       ready3, round_en3, last3, done3;
    logic [3:0] rnd1, rnd3;
    logic [7:0] rc1, rc3;
`ifdef PERM_SEQ_ABORT_EN
    logic       abort1, abort3;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt1 = 0;
    int done_cnt3 = 0;
    int d_ref;

    permutation_sequencer #(.ROUND_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1),
`ifdef PERM_SEQ_ABORT_EN
        .abort(abort1),
`endif
        .ready(ready1), .round_en(round_en1), .rnd(rnd1), .round_const(rc1),
        .last_round(last1), .done(done1)
    );

    permutation_sequencer #(.ROUND_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3),
`ifdef PERM_SEQ_ABORT_EN
        .abort(abort3),
`endif
        .ready(ready3), .round_en(round_en3), .rnd(rnd3), .round_const(rc3),
        .last_round(last3), .done(done3)
    );

    always @(negedge clk) begin
        if (done1) done_cnt1++;
        if (done3) done_cnt3++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out1(input string tag, input logic rdy, input logic ren,
                              input logic [3:0] r, input logic [7:0] c, input logic lst,
                              input logic dn);
        check({tag, ".ready"}, 32'(ready1), 32'(rdy));
        check({tag, ".round_en"}, 32'(round_en1), 32'(ren));
        check({tag, ".rnd"}, 32'(rnd1), 32'(r));
        check({tag, ".round_const"}, 32'(rc1), 32'(c));
        check({tag, ".last_round"}, 32'(last1), 32'(lst));
        check({tag, ".done"}, 32'(done1), 32'(dn));
    endtask

    // Walks n single-cycle round slots starting at first_rnd, ending in the DONE cycle.
    task automatic run_rounds1(input string tag, input int first_rnd, input int n);
        for (int i = 0; i < n; i++) begin
            int         r;
            logic [7:0] c;
            r = first_rnd + i;
            c = {4'(15 - (r - 4)), 4'(r - 4)};
            check_out1($sformatf("%s.r%0d", tag, r), 1'b0, 1'b1, 4'(r), c, r == 15, 1'b0);
            step();
        end
        check_out1({tag, ".done_cycle"}, 1'b0, 1'b0, 4'd15, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start1 = 1'b0; mode1 = P12_MODE; start3 = 1'b0; mode3 = P12_MODE;
`ifdef PERM_SEQ_ABORT_EN
        abort1 = 1'b0; abort3 = 1'b0;
`endif
        step();
        step();
        check_out1("reset", 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        check("reset3.ready", 32'(ready3), 32'd1);
        check("reset3.rnd", 32'(rnd3), 32'd0);
        rst_n = 1'b1;
        step();
        check_out1("idle", 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);

        // Full P12 run at one cycle per round.
        d_ref  = done_cnt1;
        start1 = 1'b1; mode1 = P12_MODE;
        step();
        start1 = 1'b0;
        check("p12.first_const", 32'(rc1), 32'h F0);
        run_rounds1("p12", 4, 12);
        step();
        check_out1("p12.after", 1'b1, 1'b0, 4'd15, 8'h00, 1'b0, 1'b0);
        check("p12.done_pulses", 32'(done_cnt1 - d_ref), 32'd1);

        // P8 with start held high and mode toggled during the run.
        d_ref  = done_cnt1;
        start1 = 1'b1; mode1 = P8_MODE;
        step();
        mode1 = P12_MODE;
        check("p8.first_const", 32'(rc1), 32'h B4);
        run_rounds1("p8", 8, 8);
        step();
        check("p8.ready_after", 32'(ready1), 32'd1);
        check("p8.done_pulses", 32'(done_cnt1 - d_ref), 32'd1);

        // Held start is taken again from IDLE, now as P12; reset it at rnd 9.
        step();
        start1 = 1'b0;
        check("restart.rnd", 32'(rnd1), 32'd4);
        check("restart.round_en", 32'(round_en1), 32'd1);
        for (int i = 0; i < 5; i++) step();
        check("prereset.rnd", 32'(rnd1), 32'd9);
        d_ref = done_cnt1;
        #2;
        rst_n = 1'b0;
        #1;
        check_out1("async_reset", 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        check_out1("held_reset", 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check("aborted.no_done", 32'(done_cnt1 - d_ref), 32'd0);
        start1 = 1'b1; mode1 = P12_MODE;
        step();
        start1 = 1'b0;
        run_rounds1("post_reset", 4, 12);
        step();
        check("post_reset.done_pulses", 32'(done_cnt1 - d_ref), 32'd1);

        // Three cycles per round, P8: done lands 25 cycles after acceptance.
        start3 = 1'b1; mode3 = P8_MODE;
        step();
        start3 = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            int         s;
            logic [7:0] rc;
            s  = (c - 1) / 3;
            rc = {4'(15 - (s + 4)), 4'(s + 4)};
            check($sformatf("l3.c%0d.round_en", c), 32'(round_en3), 32'(((c - 1) % 3) == 0));
            check($sformatf("l3.c%0d.rnd", c), 32'(rnd3), 32'(8 + s));
            check($sformatf("l3.c%0d.const", c), 32'(rc3), 32'(rc));
            check($sformatf("l3.c%0d.last", c), 32'(last3), 32'(s == 7));
            check($sformatf("l3.c%0d.done", c), 32'(done3), 32'd0);
            step();
        end
        check("l3.c25.done", 32'(done3), 32'd1);
        check("l3.c25.round_en", 32'(round_en3), 32'd0);
        step();
        check("l3.c26.ready", 32'(ready3), 32'd1);
        check("l3.done_pulses", 32'(done_cnt3), 32'd1);

`ifdef PERM_SEQ_ABORT_EN
        d_ref  = done_cnt1;
        start1 = 1'b1; mode1 = P12_MODE;
        step();
        start1 = 1'b0;
        step();
        step();
        check("abort.pre_rnd", 32'(rnd1), 32'd6);
        abort1 = 1'b1;
        step();
        abort1 = 1'b0;
        check_out1("abort.idle", 1'b1, 1'b0, 4'd6, 8'h00, 1'b0, 1'b0);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("abort.no_done", 32'(done_cnt1 - d_ref), 32'd0);
        run_rounds1("after_abort", 4, 12);
        step();
        check("after_abort.done_pulses", 32'(done_cnt1 - d_ref), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
